// File: rtl/shift_pkg.sv
// Shared definitions for the shared-shifter arbiter slice.
// Holds the op encoding, the op bit positions, the requester id type
// and the request record captured by the operand stage.
package shift_pkg;

  // op = {rotate, left, arith}
  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SLA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b110;

  localparam int unsigned OP_BIT_ROT   = 2;
  localparam int unsigned OP_BIT_LEFT  = 1;
  localparam int unsigned OP_BIT_ARITH = 0;

  // Widest tag the request record can carry; the top zero-extends into it.
  localparam int unsigned TAG_W_MAX = 16;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [31:0]          a;
    logic [4:0]           b;
    logic [2:0]           op;
    logic [TAG_W_MAX-1:0] tag;
  } shift_req_t;

endpackage

// File: rtl/bshift_32.sv
// 32-bit barrel shifter: rotate / logical / arithmetic, left or right.
// Ports:
//   i_a  - operand
//   i_b  - shift amount (mod 32)
//   i_op - {rotate, left, arith}
//   o_q  - result
//   o_ov - overflow, only meaningful (and only non-zero) for left arithmetic
//   o_z  - result is zero
module bshift_32
  import shift_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [4:0]  i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_q,
  output logic        o_ov,
  output logic        o_z
);

  logic [4:0]  w_rot_amt;
  logic [31:0] w_ror;
  logic [31:0] w_q;
  logic signed [31:0] w_back;

  always_comb begin
    // A left rotate by b is a right rotate by (32 - b) mod 32.
    w_rot_amt = i_op[OP_BIT_LEFT] ? 5'(5'd0 - i_b) : i_b;
    // Shift by 32 yields 0, so a zero amount degenerates cleanly to i_a.
    w_ror = (i_a >> w_rot_amt) | (i_a << (6'd32 - {1'b0, w_rot_amt}));
    if (i_op[OP_BIT_ROT])
      w_q = w_ror;
    else if (i_op[OP_BIT_LEFT])
      w_q = i_a << i_b;
    else if (i_op[OP_BIT_ARITH])
      w_q = $unsigned($signed(i_a) >>> i_b);
    else
      w_q = i_a >> i_b;
    // Left arithmetic overflows when shifting back does not restore the operand.
    w_back = $signed(w_q) >>> i_b;
    o_q  = w_q;
    o_ov = (i_op == OP_SLA) && (w_back != $signed(i_a));
    o_z  = (w_q == '0);
  end

endmodule

// File: rtl/rr_arb_2.sv
// Two-way round-robin grant with a registered priority pointer.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   i_can_acc      - downstream stage can take a request this cycle
//   i_valid0/1     - requests present
//   o_ready0/1     - grants (independent of the requester's own valid)
// The pointer moves to the non-granted requester only on a handshake.
module rr_arb_2
  import shift_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_can_acc,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_ready0,
  output logic o_ready1
);

  req_id_e r_ptr;

  always_comb begin
    o_ready0 = i_can_acc & (~i_valid1 | (r_ptr == REQ0));
    o_ready1 = i_can_acc & (~i_valid0 | (r_ptr == REQ1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= RR_INIT ? REQ1 : REQ0;
    else if (i_valid0 & o_ready0)
      r_ptr <= REQ1;
    else if (i_valid1 & o_ready1)
      r_ptr <= REQ0;
  end

endmodule

// File: rtl/shift_arb_2.sv
// Shares one bshift_32 between two requesters with round-robin arbitration.
// S1 registers the granted request and drives the shifter; S2 registers the
// result. Both sides use valid/ready handshakes.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   reqN_valid/ready             - request handshake, N = 0, 1
//   reqN_a/b/op/tag              - operand, amount, op, opaque tag
//   rsp_valid/ready              - result handshake
//   rsp_id/tag/q/ov/z            - result payload
//   busy                         - S1 or S2 occupied
module shift_arb_2
  import shift_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_b,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_q,
  output logic             rsp_ov,
  output logic             rsp_z,
  output logic             busy
);

  logic       r_run;
  logic       r_s1_full;
  shift_req_t r_s1;
  req_id_e    r_s1_id;

  logic       w_move;
  logic       w_can_acc;
  logic       w_acc0;
  logic       w_acc1;
  shift_req_t w_req;
  logic [31:0] w_q;
  logic       w_ov;
  logic       w_z;
  logic       w_unused_tag;

  // Held low through the first edge after reset release so nothing is taken then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign w_move    = r_s1_full & (~rsp_valid | rsp_ready);
  assign w_can_acc = r_run & (~r_s1_full | w_move);

  rr_arb_2 #(.RR_INIT(RR_INIT != 0)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_can_acc (w_can_acc),
    .i_valid0  (req0_valid),
    .i_valid1  (req1_valid),
    .o_ready0  (req0_ready),
    .o_ready1  (req1_ready)
  );

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;

  always_comb begin
    w_req = '0;
    if (w_acc1) begin
      w_req.a   = req1_a;
      w_req.b   = req1_b;
      w_req.op  = req1_op;
      w_req.tag = TAG_W_MAX'(req1_tag);
    end else begin
      w_req.a   = req0_a;
      w_req.b   = req0_b;
      w_req.op  = req0_op;
      w_req.tag = TAG_W_MAX'(req0_tag);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_full <= 1'b0;
      r_s1      <= '0;
      r_s1_id   <= REQ0;
    end else if (w_acc0 | w_acc1) begin
      r_s1_full <= 1'b1;
      r_s1      <= w_req;
      r_s1_id   <= w_acc1 ? REQ1 : REQ0;
    end else if (w_move) begin
      r_s1_full <= 1'b0;
    end
  end

  bshift_32 u_shift (
    .i_a  (r_s1.a),
    .i_b  (r_s1.b),
    .i_op (r_s1.op),
    .o_q  (w_q),
    .o_ov (w_ov),
    .o_z  (w_z)
  );

  // Tag bits above TAG_W are always zero and intentionally dropped here.
  assign w_unused_tag = ^r_s1.tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      rsp_q     <= '0;
      rsp_ov    <= 1'b0;
      rsp_z     <= 1'b0;
    end else if (w_move) begin
      rsp_valid <= 1'b1;
      rsp_id    <= r_s1_id;
      rsp_tag   <= r_s1.tag[TAG_W-1:0];
      rsp_q     <= w_q;
      rsp_ov    <= w_ov;
      rsp_z     <= w_z;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = r_s1_full | rsp_valid;

endmodule

// File: tb/tb_shift_arb_2.sv
module tb_shift_arb_2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_b, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ov, rsp_z, busy;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_q;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_arb_2 #(.TAG_W(4), .RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_q(rsp_q), .rsp_ov(rsp_ov), .rsp_z(rsp_z),
    .busy(busy)
  );

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [4:0]  b;
    logic [2:0]  op;
    logic [31:0] q;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                         input logic [4:0] b, input logic [2:0] op, input logic [3:0] tag);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_tag = tag;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_tag = tag;
    end
  endtask

  task automatic reset_dut();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc, acc0, acc1;
    logic [3:0] t0, t1;
    logic [31:0] snap_q;
    logic [3:0]  snap_tag;
    int n_acc;
    int k;

    vecs[0]  = '{1'b0, 32'h80000001, 5'd1,  3'b100, 32'hC0000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h80000000, 5'd4,  3'b001, 32'hF8000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h80000000, 5'd1,  3'b010, 32'h00000000, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 32'h40000000, 5'd1,  3'b011, 32'h80000000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h00000001, 5'd4,  3'b011, 32'h00000010, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h12345678, 5'd0,  3'b110, 32'h12345678, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h80000000, 5'd31, 3'b000, 32'h00000001, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h80000000, 5'd1,  3'b110, 32'h00000001, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'hF0000000, 5'd4,  3'b011, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF, 5'd8,  3'b011, 32'hFFFFFF00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'hC0000000, 5'd1,  3'b010, 32'h80000000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h12345678, 5'd8,  3'b100, 32'h78123456, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000000F, 5'd4,  3'b000, 32'h00000000, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'h7FFFFFFF, 5'd31, 3'b001, 32'h00000000, 1'b0, 1'b1};

    // Reset state, with a request already pending.
    rst_n = 1'b0; rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'h1, 5'd0, 3'b000, 4'h1);
    set_req(1'b1, 1'b0, 32'h0, 5'd0, 3'b000, 4'h0);
    #12;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
    chk("rst_q", rsp_q, 32'd0);
    chk("rst_tag_id_ov_z", {25'b0, rsp_tag, rsp_id, rsp_ov, rsp_z}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("release_ready0", {31'b0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    chk("release_no_accept", {31'b0, busy}, 32'd0);
    req0_valid = 1'b0;

    // Single-request vectors.
    for (int i = 0; i < 14; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 4'(i));
      acc = 1'b0;
      for (int w = 0; w < 10 && !acc; w++) begin
        @(negedge clk);
        acc = vecs[i].id ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
        @(posedge clk); #1;
      end
      set_req(vecs[i].id, 1'b0, vecs[i].a, vecs[i].b, vecs[i].op, 4'(i));
      if (!acc) begin
        n_chk++; n_err++;
        $display("FAIL vec%0d_accept: got timeout want handshake", i);
      end else begin
        chk($sformatf("vec%0d_lat_valid", i), {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("vec%0d_q", i), rsp_q, vecs[i].q);
        chk($sformatf("vec%0d_ov_z", i), {30'b0, rsp_ov, rsp_z}, {30'b0, vecs[i].ov, vecs[i].z});
        chk($sformatf("vec%0d_id_tag", i), {27'b0, rsp_id, rsp_tag}, {27'b0, vecs[i].id, 4'(i)});
      end
    end

    // Round-robin alternation with both requesters valid.
    reset_dut();
    t0 = 4'h0; t1 = 4'h8;
    set_req(1'b0, 1'b1, 32'h3, 5'd1, 3'b010, t0);
    set_req(1'b1, 1'b1, 32'h3, 5'd1, 3'b010, t1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (c < 6)
        chk($sformatf("rr_grant%0d", c), {30'b0, req1_ready, req0_ready},
            (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c >= 2) begin
        k = c - 2;
        chk($sformatf("rr_rsp%0d", k), {26'b0, rsp_valid, rsp_id, rsp_tag},
            {26'b0, 1'b1, 1'(k % 2), (k % 2 == 1) ? 4'(8 + k / 2) : 4'(k / 2)});
      end
      @(posedge clk); #1;
      if (acc0) begin t0 = t0 + 4'd1; req0_tag = t0; end
      if (acc1) begin t1 = t1 + 4'd1; req1_tag = t1; end
      if (c == 5) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("rr_drained", {30'b0, rsp_valid, busy}, 32'd0);

    // Full backpressure, then release.
    reset_dut();
    rsp_ready = 1'b0;
    t0 = 4'h0; t1 = 4'h8;
    set_req(1'b0, 1'b1, 32'h00000011, 5'd4, 3'b000, t0);
    set_req(1'b1, 1'b1, 32'h00000022, 5'd4, 3'b000, t1);
    n_acc = 0;
    snap_q = '0; snap_tag = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0 | acc1) n_acc++;
      if (c == 2) begin
        snap_q = rsp_q; snap_tag = rsp_tag;
        chk("bp_head", {26'b0, rsp_valid, rsp_id, rsp_tag, rsp_q[0]}, {26'b0, 1'b1, 1'b0, 4'h0, 1'b1});
      end
      if (c == 4) begin
        chk("bp_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("bp_stable_q", rsp_q, snap_q);
        chk("bp_stable_tag", {28'b0, rsp_tag}, {28'b0, snap_tag});
      end
      @(posedge clk); #1;
      if (acc0) begin t0 = t0 + 4'd1; req0_tag = t0; end
      if (acc1) begin t1 = t1 + 4'd1; req1_tag = t1; end
    end
    chk("bp_accepts", 32'(n_acc), 32'd2);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      chk($sformatf("bp_stream%0d", c), {26'b0, rsp_valid, rsp_id, rsp_tag},
          {26'b0, 1'b1, 1'(c % 2), (c % 2 == 1) ? 4'(8 + c / 2) : 4'(c / 2)});
      @(posedge clk); #1;
      if (acc0) begin t0 = t0 + 4'd1; req0_tag = t0; end
      if (acc1) begin t1 = t1 + 4'd1; req1_tag = t1; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset mid-stream with both stages full.
    reset_dut();
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'hFFFFFFFF, 5'd0, 3'b000, 4'hE);
    set_req(1'b1, 1'b1, 32'hFFFFFFFF, 5'd0, 3'b000, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_full", {30'b0, rsp_valid, busy}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", rsp_q, 32'd0);
    chk("mid_rst_flags", {25'b0, rsp_valid, busy, rsp_id, rsp_ov, rsp_z, req0_ready, req1_ready}, 32'd0);
    chk("mid_rst_tag", {28'b0, rsp_tag}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    set_req(1'b0, 1'b1, 32'h00000005, 5'd1, 3'b010, 4'h3);
    set_req(1'b1, 1'b1, 32'h00000005, 5'd1, 3'b010, 4'h4);
    @(negedge clk);
    chk("post_rst_prio", {30'b0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rsp", {26'b0, rsp_valid, rsp_id, rsp_tag}, {26'b0, 1'b1, 1'b0, 4'h3});
    chk("post_rst_q", rsp_q, 32'h0000000A);
    @(posedge clk); #1;
    chk("post_rst_no_stale", {30'b0, rsp_valid, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
